mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
- Sits between the pipeline MEM stage and the word-wide data memory.
- The data memory has a combinational read and a synchronous write on posedge clk.
- Converts pipeline byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses:
  - loads: lane extraction and sign/zero extension;
  - SH/SB: two-cycle read-modify-write;
  - misaligned requests: flagged as errors.
- Byte order is big-endian: byte offset 0 maps to data bits [31:24].

Parameters:
- Data_Width, 32, word width (fixed at 32; taken from the shared package).
- Data_Mem_Addr_Width, from package, word-address width of the data memory.
- Byte_Addr_Width, Data_Mem_Addr_Width+2, width of the pipeline byte address.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  3  ls_op_t operation code.
- req_addr  in  Byte_Addr_Width  byte address.
- req_wdata  in  Data_Width  store data; bytes/halfwords are in the low bits.
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  Data_Width  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned request; qualified by resp_valid.
- mem_addr  out  Data_Mem_Addr_Width  word address to the data memory.
- mem_we  out  1  data memory write enable.
- mem_wdata  out  Data_Width  data memory write data.
- mem_rdata  in  Data_Width  data memory combinational read data.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we forced 0 combinationally while rst_n is low.
- req_ready = (state==IDLE) and rst_n. A request is accepted on a cycle with req_valid && req_ready.
- Word address: mem_addr = req_addr[Byte_Addr_Width-1:2] in IDLE; the latched address in RMW_WR.
- Misalignment:
  - LW/SW with addr[1:0]!=0 is misaligned.
  - LH/LHU/SH with addr[0]!=0 is misaligned.
  - On acceptance of a misaligned request: no write (mem_we=0); next cycle resp_valid=1, resp_err=1, resp_rdata=0; state stays IDLE.
- Loads (accept cycle):
  - mem_rdata is sampled; selected lane is extended (LB/LH sign-extend, LBU/LHU zero-extend) and registered.
  - resp_valid=1 with resp_rdata the next cycle. Latency 1, throughput 1 per cycle.
- SW: in the accept cycle, mem_we=1 and mem_wdata=req_wdata. resp_valid the next cycle. Latency 1.
- SH/SB:
  - Accept cycle (IDLE): latch mem_rdata, word address, offset, op and the store lane; state goes to RMW_WR.
  - RMW_WR: mem_we=1; mem_wdata = latched word with the target lane replaced; req_ready=0; state goes to IDLE.
  - resp_valid the cycle after RMW_WR. Accept-to-resp latency 2; next request can be accepted one cycle after RMW_WR.
- States: IDLE, RMW_WR (RMW_WR always returns to IDLE after one cycle). No other states.
- Response: resp_valid is exactly one cycle per accepted request; there is no response backpressure.
- Back-to-back: a load immediately following an SB/SH to the same word reads the updated value, since the write completes in RMW_WR before the next accept.
- Reset mid-RMW (rst_n low during RMW_WR): the write is abandoned (mem_we=0) and no response is issued.
- Undefined req_op encodings are treated as misaligned: resp_err=1, no write.

Decomposition:
- Shared package (Generic_Pkg) gets:
  - ls_op_t enum, 3 bits: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - Byte_Addr_Width constant.
- One combinational sub-module, mips_ls_lane, provides:
  - extract(word, offset, op) giving the extended load value;
  - merge(word, offset, op, wdata) giving the merged store word;
  - misaligned(op, offset).
- The top module holds the FSM, response registers and memory mux.

Test Plan:
- Memory word 0 = 0x8899AABB; LB addr 0x0 -> resp_rdata=0xFFFFFF88, err=0, 1 cycle after accept; LBU addr 0x3 -> 0x000000BB.
- Same word: LH addr 0x2 -> 0xFFFFAABB; LHU addr 0x0 -> 0x00008899; LW addr 0x0 -> 0x8899AABB.
- SB addr 0x5, wdata 0x123456CC, word 1 initially 0x00000000:
  - req_ready low for 1 cycle; mem_we high only in RMW_WR with mem_wdata=0x00CC0000.
  - Following LW addr 0x4 -> 0x00CC0000.
- SH addr 0x6 wdata 0xBEEF onto word 0x11223344 -> memory word = 0x1122BEEF; resp_valid 2 cycles after accept.
- LW addr 0x2 and SH addr 0x1 -> resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged.
- Assert rst_n low during RMW_WR of an SB:
  - no write and no resp_valid;
  - after release req_ready=1 and all outputs are 0;
  - next LW completes normally.

Source files
------------

// File: rtl/mips_load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// mips_load_store_unit_pkg
// Shared definitions for the MEM-stage load/store unit: data/address widths,
// the load/store operation encoding and the unit's FSM state encoding.
// -----------------------------------------------------------------------------
package mips_load_store_unit_pkg;

   localparam int Data_Width          = 32;
   localparam int Data_Mem_Addr_Width = 8;
   localparam int Byte_Addr_Width     = Data_Mem_Addr_Width + 2;

   // Pipeline load/store operation codes.
   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LHU = 3'd2,
      LB  = 3'd3,
      LBU = 3'd4,
      SW  = 3'd5,
      SH  = 3'd6,
      SB  = 3'd7
   } ls_op_t;

   // Unit state: IDLE accepts requests, RMW_WR performs the write half of SH/SB.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } ls_state_t;

endpackage

// File: rtl/mips_load_store_unit_lane.sv
// -----------------------------------------------------------------------------
// mips_ls_lane
// Purely combinational big-endian lane logic (byte offset 0 = bits [31:24]).
// Ports:
//   acc_word/acc_offset/acc_op  : word read in the accept cycle and the request
//   acc_load_data               : selected lane, sign/zero extended (0 for stores)
//   acc_misaligned              : request alignment violation or unknown op
//   rmw_word/rmw_offset/rmw_op  : latched word and request of a pending SH/SB
//   rmw_lane                    : latched store data (byte/halfword in low bits)
//   rmw_merged                  : latched word with the target lane replaced
// -----------------------------------------------------------------------------
module mips_ls_lane
   import mips_load_store_unit_pkg::*;
(
   input  logic [Data_Width-1:0] acc_word,
   input  logic [1:0]            acc_offset,
   input  ls_op_t                acc_op,
   output logic [Data_Width-1:0] acc_load_data,
   output logic                  acc_misaligned,
   input  logic [Data_Width-1:0] rmw_word,
   input  logic [1:0]            rmw_offset,
   input  ls_op_t                rmw_op,
   input  logic [15:0]           rmw_lane,
   output logic [Data_Width-1:0] rmw_merged
);

   logic [7:0]  acc_byte_s;
   logic [15:0] acc_half_s;

   // Select the addressed byte and halfword of the read word.
   always_comb begin
      acc_byte_s = 8'h00;
      case (acc_offset)
         2'd0:    acc_byte_s = acc_word[31:24];
         2'd1:    acc_byte_s = acc_word[23:16];
         2'd2:    acc_byte_s = acc_word[15:8];
         2'd3:    acc_byte_s = acc_word[7:0];
         default: acc_byte_s = 8'h00;
      endcase
      if (acc_offset[1]) begin
         acc_half_s = acc_word[15:0];
      end else begin
         acc_half_s = acc_word[31:16];
      end
   end

   // Extend the selected lane according to the load type.
   always_comb begin
      acc_load_data = 32'h0000_0000;
      case (acc_op)
         LW:      acc_load_data = acc_word;
         LH:      acc_load_data = {{16{acc_half_s[15]}}, acc_half_s};
         LHU:     acc_load_data = {16'h0000, acc_half_s};
         LB:      acc_load_data = {{24{acc_byte_s[7]}}, acc_byte_s};
         LBU:     acc_load_data = {24'h00_0000, acc_byte_s};
         default: acc_load_data = 32'h0000_0000;
      endcase
   end

   // Alignment rule by access size; anything unrecognised is rejected too.
   always_comb begin
      acc_misaligned = 1'b1;
      case (acc_op)
         LW, SW:      acc_misaligned = (acc_offset != 2'd0);
         LH, LHU, SH: acc_misaligned = acc_offset[0];
         LB, LBU, SB: acc_misaligned = 1'b0;
         default:     acc_misaligned = 1'b1;
      endcase
   end

   // Replace the target lane of the latched word with the store data.
   always_comb begin
      rmw_merged = rmw_word;
      case (rmw_op)
         SB: begin
            case (rmw_offset)
               2'd0:    rmw_merged[31:24] = rmw_lane[7:0];
               2'd1:    rmw_merged[23:16] = rmw_lane[7:0];
               2'd2:    rmw_merged[15:8]  = rmw_lane[7:0];
               2'd3:    rmw_merged[7:0]   = rmw_lane[7:0];
               default: rmw_merged        = rmw_word;
            endcase
         end
         SH: begin
            if (rmw_offset[1]) begin
               rmw_merged[15:0] = rmw_lane;
            end else begin
               rmw_merged[31:16] = rmw_lane;
            end
         end
         default: rmw_merged = rmw_word;
      endcase
   end

endmodule

// File: rtl/mips_load_store_unit.sv
// -----------------------------------------------------------------------------
// mips_load_store_unit
// Bridges pipeline byte-addressed loads/stores onto a word-wide data memory
// (combinational read, synchronous write). Loads and SW complete in one cycle;
// SH/SB are read in the accept cycle and written back in RMW_WR.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready                : request handshake
//   req_op/req_addr/req_wdata          : operation, byte address, store data
//   resp_valid/resp_rdata/resp_err     : one-cycle completion pulse and result
//   mem_addr/mem_we/mem_wdata/mem_rdata: data memory interface
// -----------------------------------------------------------------------------
module mips_load_store_unit
   import mips_load_store_unit_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [2:0]                     req_op,
   input  logic [Byte_Addr_Width-1:0]     req_addr,
   input  logic [Data_Width-1:0]          req_wdata,
   output logic                           resp_valid,
   output logic [Data_Width-1:0]          resp_rdata,
   output logic                           resp_err,
   output logic [Data_Mem_Addr_Width-1:0] mem_addr,
   output logic                           mem_we,
   output logic [Data_Width-1:0]          mem_wdata,
   input  logic [Data_Width-1:0]          mem_rdata
);

   ls_state_t                      state_r;
   ls_state_t                      next_state_s;
   ls_op_t                         req_op_s;
   logic                           accept_s;
   logic                           capture_s;
   logic                           mem_we_s;
   logic                           resp_valid_s;
   logic [Data_Width-1:0]          resp_rdata_s;
   logic                           resp_err_s;
   logic [Data_Width-1:0]          acc_load_data_s;
   logic                           acc_misaligned_s;
   logic [Data_Width-1:0]          rmw_merged_s;

   // State captured in the accept cycle of an SH/SB.
   logic [Data_Width-1:0]          rmw_word_r;
   logic [Data_Mem_Addr_Width-1:0] rmw_addr_r;
   logic [1:0]                     rmw_off_r;
   ls_op_t                         rmw_op_r;
   logic [15:0]                    rmw_lane_r;

   assign req_op_s  = ls_op_t'(req_op);
   assign req_ready = (state_r == IDLE) && rst_n;
   assign accept_s  = req_valid && req_ready;
   // Gated by rst_n so a reset in RMW_WR can never leak a partial write.
   assign mem_we    = mem_we_s && rst_n;

   mips_ls_lane u_lane (
      .acc_word       (mem_rdata),
      .acc_offset     (req_addr[1:0]),
      .acc_op         (req_op_s),
      .acc_load_data  (acc_load_data_s),
      .acc_misaligned (acc_misaligned_s),
      .rmw_word       (rmw_word_r),
      .rmw_offset     (rmw_off_r),
      .rmw_op         (rmw_op_r),
      .rmw_lane       (rmw_lane_r),
      .rmw_merged     (rmw_merged_s)
   );

   // Next-state, memory write enable and next response values.
   always_comb begin
      next_state_s = state_r;
      mem_we_s     = 1'b0;
      capture_s    = 1'b0;
      resp_valid_s = 1'b0;
      resp_rdata_s = 32'h0000_0000;
      resp_err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (acc_misaligned_s) begin
                  resp_valid_s = 1'b1;
                  resp_err_s   = 1'b1;
               end else begin
                  case (req_op_s)
                     SW: begin
                        mem_we_s     = 1'b1;
                        resp_valid_s = 1'b1;
                     end
                     SH, SB: begin
                        capture_s    = 1'b1;
                        next_state_s = RMW_WR;
                     end
                     default: begin
                        resp_valid_s = 1'b1;
                        resp_rdata_s = acc_load_data_s;
                     end
                  endcase
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         RMW_WR: begin
            // Response for the SH/SB is registered at the end of the write cycle.
            mem_we_s     = 1'b1;
            resp_valid_s = 1'b1;
            next_state_s = IDLE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Memory address/data mux: live request in IDLE, latched RMW word in RMW_WR.
   always_comb begin
      mem_addr  = req_addr[Byte_Addr_Width-1:2];
      mem_wdata = req_wdata;
      case (state_r)
         RMW_WR: begin
            mem_addr  = rmw_addr_r;
            mem_wdata = rmw_merged_s;
         end
         default: begin
            mem_addr  = req_addr[Byte_Addr_Width-1:2];
            mem_wdata = req_wdata;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= resp_valid_s;
         resp_rdata <= resp_rdata_s;
         resp_err   <= resp_err_s;
      end
   end

   // Capture the read word and request fields of an accepted SH/SB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmw_word_r <= 32'h0000_0000;
         rmw_addr_r <= '0;
         rmw_off_r  <= 2'd0;
         rmw_op_r   <= LW;
         rmw_lane_r <= 16'h0000;
      end else if (capture_s) begin
         rmw_word_r <= mem_rdata;
         rmw_addr_r <= req_addr[Byte_Addr_Width-1:2];
         rmw_off_r  <= req_addr[1:0];
         rmw_op_r   <= req_op_s;
         rmw_lane_r <= req_wdata[15:0];
      end else begin
         rmw_word_r <= rmw_word_r;
         rmw_addr_r <= rmw_addr_r;
         rmw_off_r  <= rmw_off_r;
         rmw_op_r   <= rmw_op_r;
         rmw_lane_r <= rmw_lane_r;
      end
   end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_load_store_unit
// Scoreboard bench: a byte-array reference model predicts every response when
// a request is issued; a negedge monitor pops and compares on resp_valid.
// -----------------------------------------------------------------------------
module tb_mips_load_store_unit;
   import mips_load_store_unit_pkg::*;

   localparam int AW = Data_Mem_Addr_Width;
   localparam int BW = Byte_Addr_Width;
   localparam int NW = 1 << AW;
   localparam int NB = NW * 4;
   localparam int TW = 16;   // words used by the tests

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_op = 3'd0;
   logic [BW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = 32'h0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   mem [0:NW-1];
   logic [7:0]    ref_bytes [0:NB-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [31:0]   bd_data = 32'h0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_cnt = 0;

   mips_load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, synchronous write, plus a backdoor port.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (bd_we) mem[bd_addr] <= bd_data;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete, required completion before timeout");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte array, big-endian) ----------------
   function automatic int op_size(input logic [2:0] op);
      case (op)
         3'd0, 3'd5:       return 4;
         3'd1, 3'd2, 3'd6: return 2;
         default:          return 1;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input int a);
      int b = a - (a % 4);
      return {ref_bytes[b], ref_bytes[b+1], ref_bytes[b+2], ref_bytes[b+3]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
      logic [15:0] h;
      logic [7:0]  b;
      b = ref_bytes[a];
      h = {ref_bytes[a], ref_bytes[(a+1) % NB]};
      case (op)
         3'd0:    return ref_word(a);
         3'd1:    return {{16{h[15]}}, h};
         3'd2:    return {16'h0, h};
         3'd3:    return {{24{b[7]}}, b};
         default: return {24'h0, b};
      endcase
   endfunction

   task automatic set_word(input int w, input logic [31:0] v);
      bd_we = 1'b1; bd_addr = AW'(w); bd_data = v;
      for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = v[31-8*i -: 8];
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Issue one request, predict its response, and check the write-side timing.
   task automatic send(input logic [2:0] op, input int addr, input logic [31:0] wdata);
      int   n;
      exp_t e;
      logic mis, rmw;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got req_ready=0, expected 1");
         return;
      end
      req_valid = 1'b1; req_op = op; req_addr = BW'(addr); req_wdata = wdata;
      mis = (addr % op_size(op)) != 0;
      rmw = !mis && (op == 3'd6 || op == 3'd7);
      e.err = mis; e.rdata = 32'h0; e.cyc = cyc + (rmw ? 2 : 1);
      if (!mis) begin
         case (op)
            3'd5: for (int i = 0; i < 4; i++) ref_bytes[addr+i] = wdata[31-8*i -: 8];
            3'd6: begin ref_bytes[addr] = wdata[15:8]; ref_bytes[addr+1] = wdata[7:0]; end
            3'd7: ref_bytes[addr] = wdata[7:0];
            default: e.rdata = ref_load(op, addr);
         endcase
      end
      exp_q.push_back(e);
      #1;
      check("accept_mem_we", 32'(mem_we), 32'(op == 3'd5 && !mis));
      if (op == 3'd5 && !mis) check("sw_mem_wdata", mem_wdata, wdata);
      @(negedge clk);
      req_valid = 1'b0;
      if (rmw) begin
         check("rmw_req_ready", 32'(req_ready), 32'd0);
         check("rmw_mem_we", 32'(mem_we), 32'd1);
         check("rmw_mem_addr", 32'(mem_addr), 32'(addr / 4));
         check("rmw_mem_wdata", mem_wdata, ref_word(addr));
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every resp_valid pulse must match the oldest predicted response.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, mon_e.rdata);
            check("resp_err", 32'(resp_err), 32'(mon_e.err));
            check("resp_latency", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      int w0;
      int op, addr;
      repeat (2) @(negedge clk);
      for (int w = 0; w < TW; w++) set_word(w, $urandom);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Directed loads on word 0 = 8899AABB.
      set_word(0, 32'h8899_AABB);
      set_word(1, 32'h0000_0000);
      send(3'd3, 0, 32'h0);
      send(3'd4, 3, 32'h0);
      send(3'd1, 2, 32'h0);
      send(3'd2, 0, 32'h0);
      send(3'd0, 0, 32'h0);
      // SB into word 1, then an immediate load of the same word.
      send(3'd7, 5, 32'h1234_56CC);
      send(3'd0, 4, 32'h0);
      drain();
      check("sb_mem_word1", mem[1], 32'h00CC_0000);

      set_word(1, 32'h1122_3344);
      send(3'd6, 6, 32'h0000_BEEF);
      drain();
      check("sh_mem_word1", mem[1], 32'h1122_BEEF);

      // Misaligned requests: error response, no writes.
      w0 = we_cnt;
      send(3'd0, 2, 32'h0);
      send(3'd6, 1, 32'hFFFF_FFFF);
      drain();
      check("mis_no_write", we_cnt, w0);
      check("mis_mem_word0", mem[0], 32'h8899_AABB);

      // Reset during RMW_WR of an SB: write abandoned, no response.
      req_valid = 1'b1; req_op = 3'd7; req_addr = BW'(9); req_wdata = 32'h0000_0077;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_rmw_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_req_ready", 32'(req_ready), 32'd1);
      check("rel_resp_valid", 32'(resp_valid), 32'd0);
      check("rel_resp_rdata", resp_rdata, 32'd0);
      check("rel_resp_err", 32'(resp_err), 32'd0);
      check("rel_mem_we", 32'(mem_we), 32'd0);
      check("rst_rmw_mem_word2", mem[2], ref_word(8));
      repeat (3) @(negedge clk);
      send(3'd0, 8, 32'h0);
      drain();

      // Randomised traffic across the test region.
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 7);
         addr = $urandom_range(0, TW * 4 - 1);
         if ($urandom_range(0, 2) != 0) addr = addr - (addr % op_size(3'(op)));
         send(3'(op), addr, $urandom);
         if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
      drain();
      for (int w = 0; w < TW; w++) check("final_mem", mem[w], ref_word(4 * w));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
